// File: rtl/pvr_tex_pkg.sv
// rtl/pvr_tex_pkg.sv - shared texel fetch encodings, state enum and ARGB expansion
package pvr_tex_pkg;

    localparam logic [1:0] PIX_1555 = 2'd0;
    localparam logic [1:0] PIX_565  = 2'd1;
    localparam logic [1:0] PIX_4444 = 2'd2;

    typedef enum logic [2:0] {IDLE, CALC, REQ, WAIT, OUT} fetch_state_t;

    // Sizes are powers of two, so the highest set bit is the log2.
    function automatic logic [3:0] size_log2(input logic [10:0] s);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 11; i++) begin
            if (s[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Reserved format 3 decodes as RGB565.
    function automatic logic [31:0] expand_16_to_argb(input logic [15:0] p, input logic [1:0] fmt);
        logic [31:0] r;
        r = {8'hFF, p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
        case (fmt)
            PIX_1555: r = {{8{p[15]}}, p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]};
            PIX_4444: r = {p[15:12], p[15:12], p[11:8], p[11:8], p[7:4], p[7:4], p[3:0], p[3:0]};
            PIX_565, 2'd3: r = {8'hFF, p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tex_twiddle_idx.sv
// rtl/tex_twiddle_idx.sv - texel index from U/V, linear or twiddled (Morton) layout
module tex_twiddle_idx
    import pvr_tex_pkg::*;
(
    input  logic [9:0]  u,
    input  logic [9:0]  v,
    input  logic [10:0] u_size,
    input  logic [10:0] v_size,
    input  logic        twiddled,
    output logic [19:0] idx
);

    logic [3:0]  lu, lv, m;
    logic [9:0]  um, vm, big;
    logic [19:0] tw_idx, lin_idx;

    always_comb begin
        lu  = size_log2(u_size);
        lv  = size_log2(v_size);
        m   = (lu < lv) ? lu : lv;
        um  = u & 10'(u_size - 11'd1);
        vm  = v & 10'(v_size - 11'd1);
        big = (lu > lv) ? um : vm;
        // Leftover high bits of the longer side sit above the 2*m interleaved bits.
        tw_idx = (20'(big) >> m) << {m, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (4'(i) < m) begin
                tw_idx[2*i]   = vm[i];
                tw_idx[2*i+1] = um[i];
            end
        end
        lin_idx = (20'(vm) << lu) | 20'(um);
        idx     = twiddled ? tw_idx : lin_idx;
    end

endmodule

// File: rtl/tex_fetch.sv
// rtl/tex_fetch.sv - texel fetch: index, VRAM word read, lane select, ARGB8888 expand; option TEX_WORD_CACHE_EN
module tex_fetch
    import pvr_tex_pkg::*;
#(
    parameter int VRAM_AW = 20,
    parameter int BASE_W  = 21
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9:0]         u_in,
    input  logic [9:0]         v_in,
    input  logic [10:0]        tex_u_size_full,
    input  logic [10:0]        tex_v_size_full,
    input  logic [BASE_W-1:0]  tex_base,
    input  logic               tex_twiddled,
    input  logic [1:0]         pix_fmt,
    output logic               vram_rd,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic               vram_wait,
    input  logic               vram_valid,
    input  logic [63:0]        vram_din,
    output logic               texel_valid,
    input  logic               texel_ready,
    output logic [31:0]        texel_argb
);

    fetch_state_t       state, state_nxt;
    logic [9:0]         u_q, v_q;
    logic [10:0]        usz_q, vsz_q;
    logic [BASE_W-1:0]  base_q;
    logic               twid_q;
    logic [1:0]         fmt_q;
    logic [VRAM_AW-1:0] addr_q, calc_addr;
    logic [1:0]         lane_q;
    logic [31:0]        texel_q;
    logic [19:0]        idx;
    logic               hit, data_take;
    logic [63:0]        data_word;
    logic [15:0]        lane_word;

    tex_twiddle_idx u_idx (
        .u        (u_q),
        .v        (v_q),
        .u_size   (usz_q),
        .v_size   (vsz_q),
        .twiddled (twid_q),
        .idx      (idx)
    );

    assign calc_addr = VRAM_AW'(base_q + BASE_W'(idx[19:2]));

`ifdef TEX_WORD_CACHE_EN
    logic               cache_valid, hit_q;
    logic [VRAM_AW-1:0] cache_addr;
    logic [63:0]        cache_data;

    assign hit       = hit_q;
    assign data_word = hit_q ? cache_data : vram_din;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cache_valid <= 1'b0;
            cache_addr  <= '0;
            cache_data  <= '0;
            hit_q       <= 1'b0;
        end else begin
            if (state == IDLE && in_valid && tex_base != base_q) cache_valid <= 1'b0;
            if (state == CALC) hit_q <= cache_valid && (cache_addr == calc_addr);
            if (data_take && !hit_q) begin
                cache_valid <= 1'b1;
                cache_addr  <= addr_q;
                cache_data  <= vram_din;
            end
        end
    end
`else
    assign hit       = 1'b0;
    assign data_word = vram_din;
`endif

    assign lane_word = data_word[{lane_q, 4'b0000} +: 16];
    assign data_take = (state == REQ && (hit || (!vram_wait && vram_valid)))
                    || (state == WAIT && vram_valid);

    assign in_ready    = (state == IDLE);
    assign vram_rd     = (state == REQ) && !hit;
    assign vram_addr   = addr_q;
    assign texel_valid = (state == OUT);
    assign texel_argb  = texel_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: state_nxt = REQ;
            REQ: begin
                if (hit) state_nxt = OUT;
                else if (!vram_wait) state_nxt = vram_valid ? OUT : WAIT;
            end
            WAIT: if (vram_valid) state_nxt = OUT;
            OUT:  if (texel_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            usz_q   <= '0;
            vsz_q   <= '0;
            base_q  <= '0;
            twid_q  <= 1'b0;
            fmt_q   <= '0;
            addr_q  <= '0;
            lane_q  <= '0;
            texel_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                u_q    <= u_in;
                v_q    <= v_in;
                usz_q  <= tex_u_size_full;
                vsz_q  <= tex_v_size_full;
                base_q <= tex_base;
                twid_q <= tex_twiddled;
                fmt_q  <= pix_fmt;
            end
            if (state == CALC) begin
                addr_q <= calc_addr;
                lane_q <= idx[1:0];
            end
            if (data_take) texel_q <= expand_16_to_argb(lane_word, fmt_q);
        end
    end

endmodule
